// File: rtl/mips_pkg.sv
// Shared types and default constants for the MIPS fetch front end.
package mips_pkg;

  localparam int unsigned ADDR_W_DEFAULT   = 16;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DECIDE = 2'd2
  } fetchState_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: jump beats taken branch, which beats sequential advance.
module pc_next_calc #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned PC_INC = 1
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seqPc;

  // Priority mux; branch offset is two's complement, so a plain modulo add sign-extends by value.
  always_comb begin
    seqPc = pc + ADDR_W'(PC_INC);
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = seqPc + branch_offset;
    end else begin
      next_pc = seqPc;
    end
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC register, instruction-fetch handshake sequencer and ack-timeout watchdog.
module pc_fetch_controller
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned PC_INC      = 1,
  parameter int unsigned RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  fetchState_t       state, stateNext;
  logic [ADDR_W-1:0] pcQ, pcNext, redirectPc;
  logic [CNT_W-1:0]  cntQ, cntNext, cntInc;
  logic              reqQ, reqNext;
  logic              validQ, validNext;
  logic              errQ, errNext;

  pc_next_calc #(
    .ADDR_W(ADDR_W),
    .PC_INC(PC_INC)
  ) uNextPc (
    .pc           (pcQ),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .next_pc      (redirectPc)
  );

  // State, PC, request, pulse, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pcQ    <= ADDR_W'(RESET_PC);
      cntQ   <= '0;
      reqQ   <= 1'b0;
      validQ <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      state  <= stateNext;
      pcQ    <= pcNext;
      cntQ   <= cntNext;
      reqQ   <= reqNext;
      validQ <= validNext;
      errQ   <= errNext;
    end
  end

  // Next-state logic. The request flop rises one cycle after entering REQ, so a
  // zero-wait fetch spans REQ(req low), REQ(req high + ack), DECIDE.
  always_comb begin
    stateNext = state;
    pcNext    = pcQ;
    cntNext   = cntQ;
    reqNext   = 1'b0;
    validNext = 1'b0;
    errNext   = errQ;
    cntInc    = cntQ + CNT_W'(1);
    case (state)
      IDLE: begin
        stateNext = REQ;
      end
      REQ: begin
        if (reqQ && imem_ack) begin
          stateNext = DECIDE;
          validNext = 1'b1;
          cntNext   = '0;
        end else begin
          reqNext = 1'b1;
          if (reqQ) begin
            // Timeout keeps the request high, which reissues the same address.
            if (cntInc == CNT_W'(ACK_TIMEOUT)) begin
              errNext = 1'b1;
              cntNext = '0;
            end else begin
              cntNext = cntInc;
            end
          end
        end
      end
      DECIDE: begin
        if (!stall) begin
          pcNext    = redirectPc;
          stateNext = REQ;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign imem_req    = reqQ;
  assign imem_addr   = pcQ;
  assign instr_valid = validQ;
  assign fetch_err   = errQ;
  assign pc          = pcQ;
  assign pc_plus     = pcQ + ADDR_W'(PC_INC);

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Scoreboard bench for pc_fetch_controller: expected fetch addresses are queued by
// the stimulus and checked by a monitor on every ack and instr_valid pulse.
module tb_pc_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        stall;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        fetch_err;

  logic        ackEnable;
  logic        ackForce;
  logic [15:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lastValid = -1;
  int          spacing = 0;

  pc_fetch_controller #(
    .ADDR_W(16),
    .PC_INC(1),
    .RESET_PC(0),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .fetch_err    (fetch_err)
  );

  // Memory model: zero-wait ack while enabled, plus a forced ack for the IDLE test.
  assign imem_ack = ackForce | (ackEnable & imem_req);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      cycle++;
      if (imem_req && imem_ack) begin
        if (expQ.size() == 0) failNow("unexpected_ack");
        else check("fetch_addr", imem_addr, expQ[0]);
      end
      if (instr_valid) begin
        if (expQ.size() == 0) failNow("unexpected_valid");
        else check("valid_pc", pc, expQ.pop_front());
        if (spacing != 0 && lastValid >= 0) checkInt("valid_spacing", cycle - lastValid, spacing);
        lastValid = cycle;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (expQ.size() != 0) begin
      failNow("drain_timeout");
      expQ.delete();
    end
  endtask

  task automatic waitReq(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!imem_req && n < budget);
    if (!imem_req) failNow("req_timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ackEnable = 1'b1;
    ackForce = 1'b0;
    stall = 1'b0;
    jump = 1'b0;
    jump_target = '0;
    branch_taken = 1'b0;
    branch_offset = '0;
    fork
      monitorLoop();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_pc_plus", pc_plus, 16'h0001);
    checkBit("rst_req", imem_req, 1'b0);
    checkBit("rst_valid", instr_valid, 1'b0);
    checkBit("rst_err", fetch_err, 1'b0);

    // Zero-wait sequential fetches, one every 3 cycles
    for (int i = 0; i < 4; i++) expQ.push_back(16'(i));
    spacing = 3;
    lastValid = -1;
    rst_n = 1'b1;
    drain(40);
    spacing = 0;
    checkBit("seq_err", fetch_err, 1'b0);

    // Stall in DECIDE beats a held jump
    stall = 1'b1;
    jump = 1'b1;
    jump_target = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      check("stall_pc", pc, 16'h0003);
      checkBit("stall_valid", instr_valid, 1'b0);
      checkBit("stall_req", imem_req, 1'b0);
    end
    expQ.push_back(16'h0040);
    stall = 1'b0;
    @(negedge clk);
    #2;
    check("jump_pc", pc, 16'h0040);
    check("jump_addr", imem_addr, 16'h0040);
    drain(20);

    // Jump beats branch, then branch alone with negative offset
    jump_target = 16'h0010;
    expQ.push_back(16'h0010);
    drain(20);
    jump_target = 16'h0100;
    branch_taken = 1'b1;
    branch_offset = 16'hFFFE;
    expQ.push_back(16'h0100);
    drain(20);
    jump_target = 16'h0010;
    branch_taken = 1'b0;
    expQ.push_back(16'h0010);
    drain(20);
    jump = 1'b0;
    branch_taken = 1'b1;
    expQ.push_back(16'h000F);
    drain(20);

    // Sequential wrap at the top of the address space
    branch_taken = 1'b0;
    jump = 1'b1;
    jump_target = 16'hFFFF;
    expQ.push_back(16'hFFFF);
    drain(20);
    check("wrap_pc_plus_hi", pc_plus, 16'h0000);
    jump = 1'b0;
    expQ.push_back(16'h0000);
    drain(20);
    check("wrap_pc", pc, 16'h0000);
    check("wrap_pc_plus", pc_plus, 16'h0001);

    // Withheld ack: timeout after 15 cycles, request held, sticky error
    ackEnable = 1'b0;
    expQ.push_back(16'h0001);
    waitReq(10);
    repeat (14) @(negedge clk);
    #2;
    checkBit("to_err_early", fetch_err, 1'b0);
    @(negedge clk);
    #2;
    checkBit("to_err_set", fetch_err, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    checkBit("to_err_hold", fetch_err, 1'b1);
    checkBit("to_req_hold", imem_req, 1'b1);
    check("to_addr_hold", imem_addr, 16'h0001);
    ackEnable = 1'b1;
    drain(10);
    checkBit("to_err_sticky", fetch_err, 1'b1);

    // Reset mid-request, then an ack in IDLE is ignored
    jump = 1'b1;
    jump_target = 16'h0023;
    ackEnable = 1'b0;
    waitReq(10);
    check("mid_pc", pc, 16'h0023);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check("mid_rst_pc", pc, 16'h0000);
    checkBit("mid_rst_req", imem_req, 1'b0);
    checkBit("mid_rst_err", fetch_err, 1'b0);
    checkBit("mid_rst_valid", instr_valid, 1'b0);
    rst_n = 1'b1;
    jump = 1'b0;
    ackForce = 1'b1;
    @(negedge clk);
    #2;
    checkBit("idle_ack_valid", instr_valid, 1'b0);
    checkBit("idle_ack_req", imem_req, 1'b0);
    ackForce = 1'b0;
    ackEnable = 1'b1;
    expQ.push_back(16'h0000);
    drain(20);
    checkBit("post_rst_err", fetch_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
